// File: rtl/uart_baud_pkg.sv
// Shared types and helpers for the fractional UART baud generator.
package uart_baud_pkg;

    localparam int MIN_DIV_INT = 2;

    typedef struct packed {
        logic [31:0] div_int;
        logic [31:0] div_frac;
    } baud_div_t;

    // Rounded clocks per oversample tick, in units of 1/2^frac_w.
    function automatic baud_div_t calc_div(
        input longint clock_freq,
        input longint baud,
        input longint oversample,
        input int     frac_w
    );
        longint    den;
        longint    q;
        baud_div_t d;
        den        = baud * oversample;
        q          = ((clock_freq <<< frac_w) + (den >>> 1)) / den;
        d.div_int  = 32'(q >>> frac_w);
        d.div_frac = 32'(q - ((q >>> frac_w) <<< frac_w));
        return d;
    endfunction

endpackage

// File: rtl/uart_baud_frac_div.sv
// Oversample divider: period counter, fractional phase accumulator, os_tick.
// UART_BAUD_FRAC_EN enables the accumulator; otherwise the integer part only.
module uart_baud_frac_div #(
    parameter int DIV_W  = 16,
    parameter int FRAC_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_run,
    input  logic              i_clr,
    input  logic              i_acc_clr,
    input  logic [DIV_W-1:0]  i_div_int,
    input  logic [FRAC_W-1:0] i_div_frac,
    output logic              o_wrap,
    output logic              o_os_tick
);
    logic [DIV_W-1:0] r_cnt;
    logic             r_os;
    logic             w_carry;
    logic             w_term;

    // >= rather than == so a divisor shrunk while frozen still wraps.
    assign w_term = ({1'b0, r_cnt} + (DIV_W+1)'(1))
                    >= ({1'b0, i_div_int} + (DIV_W+1)'(w_carry));
    assign o_wrap    = i_run & ~i_clr & w_term;
    assign o_os_tick = r_os;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
            r_os  <= 1'b0;
        end else if (i_clr) begin
            r_cnt <= '0;
            r_os  <= 1'b0;
        end else if (i_run) begin
            r_os  <= w_term;
            r_cnt <= w_term ? '0 : r_cnt + DIV_W'(1);
        end else begin
            r_os  <= 1'b0;
        end
    end

`ifdef UART_BAUD_FRAC_EN
    logic [FRAC_W-1:0] r_acc;
    logic              r_carry;
    logic [FRAC_W:0]   w_sum;

    assign w_sum   = {1'b0, r_acc} + {1'b0, i_div_frac};
    assign w_carry = r_carry;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_acc   <= '0;
            r_carry <= 1'b0;
        end else if (i_clr) begin
            r_acc   <= '0;
            r_carry <= 1'b0;
        end else begin
            if (o_wrap) begin
                {r_carry, r_acc} <= w_sum;
            end
            if (i_acc_clr) begin
                r_acc <= '0;
            end
        end
    end
`else
    logic w_unused;
    assign w_carry  = 1'b0;
    assign w_unused = ^{i_div_frac, i_acc_clr};
`endif

endmodule

// File: rtl/uart_baud_gen_frac.sv
// Fractional runtime-programmable UART baud generator (os, bit, mid-bit ticks).
// Define UART_BAUD_FRAC_EN to enable the fractional divisor accumulator.
module uart_baud_gen_frac #(
    parameter int CLOCK_FREQ   = 50000000,
    parameter int DEFAULT_BAUD = 9600,
    parameter int OVERSAMPLE   = 16,
    parameter int DIV_W        = 16,
    parameter int FRAC_W       = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              cfg_wr,
    input  logic [DIV_W-1:0]  cfg_div_int,
    input  logic [FRAC_W-1:0] cfg_div_frac,
    input  logic              resync,
    output logic              os_tick,
    output logic              baud_tick,
    output logic              mid_tick,
    output logic              cfg_err,
    output logic              cfg_pend
);
    import uart_baud_pkg::*;

    localparam int OS_W = $clog2(OVERSAMPLE);
`ifdef UART_BAUD_FRAC_EN
    localparam int EFF_FW = FRAC_W;
`else
    localparam int EFF_FW = 0;
`endif
    localparam baud_div_t DEF_DIV = calc_div(longint'(CLOCK_FREQ),
                                             longint'(DEFAULT_BAUD),
                                             longint'(OVERSAMPLE),
                                             EFF_FW);
    localparam logic [DIV_W-1:0]  DEF_INT  = DEF_DIV.div_int[DIV_W-1:0];
    localparam logic [FRAC_W-1:0] DEF_FRAC = DEF_DIV.div_frac[FRAC_W-1:0];

    logic [DIV_W-1:0]  r_sh_int;
    logic [DIV_W-1:0]  r_act_int;
    logic [DIV_W-1:0]  w_new_int;
    logic [FRAC_W-1:0] r_sh_frac;
    logic [FRAC_W-1:0] r_act_frac;
    logic [FRAC_W-1:0] w_new_frac;
    logic [FRAC_W-1:0] w_cfg_frac;
    logic [OS_W-1:0]   r_os_cnt;
    logic              r_pend;
    logic              r_err;
    logic              r_baud;
    logic              r_mid;
    logic              w_wr_ok;
    logic              w_pend_any;
    logic              w_apply;
    logic              w_wrap;
    logic              w_os_tick;
    logic              w_baud_ev;
    logic              w_mid_ev;

`ifdef UART_BAUD_FRAC_EN
    assign w_cfg_frac = cfg_div_frac;
`else
    logic w_unused_frac;
    assign w_cfg_frac    = '0;
    assign w_unused_frac = ^cfg_div_frac;
`endif

    assign w_wr_ok    = cfg_wr & (cfg_div_int >= DIV_W'(MIN_DIV_INT));
    // A write in the applying cycle goes straight to the active divisor.
    assign w_new_int  = w_wr_ok ? cfg_div_int : r_sh_int;
    assign w_new_frac = w_wr_ok ? w_cfg_frac : r_sh_frac;
    assign w_pend_any = r_pend | w_wr_ok;
    assign w_baud_ev  = w_wrap & (r_os_cnt == OS_W'(OVERSAMPLE - 1));
    assign w_mid_ev   = w_wrap & (r_os_cnt == OS_W'(OVERSAMPLE / 2 - 1));
    assign w_apply    = w_pend_any & (resync | ~en | w_baud_ev);

    uart_baud_frac_div #(
        .DIV_W  (DIV_W),
        .FRAC_W (FRAC_W)
    ) u_div (
        .clk        (clk),
        .rst        (rst),
        .i_run      (en),
        .i_clr      (resync),
        .i_acc_clr  (w_apply),
        .i_div_int  (r_act_int),
        .i_div_frac (r_act_frac),
        .o_wrap     (w_wrap),
        .o_os_tick  (w_os_tick)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sh_int   <= DEF_INT;
            r_sh_frac  <= DEF_FRAC;
            r_act_int  <= DEF_INT;
            r_act_frac <= DEF_FRAC;
            r_pend     <= 1'b0;
            r_err      <= 1'b0;
            r_baud     <= 1'b0;
            r_mid      <= 1'b0;
            r_os_cnt   <= '0;
        end else begin
            r_err  <= cfg_wr & ~w_wr_ok;
            r_baud <= w_baud_ev;
            r_mid  <= w_mid_ev;
            if (w_wr_ok) begin
                r_sh_int  <= cfg_div_int;
                r_sh_frac <= w_cfg_frac;
            end
            if (w_apply) begin
                r_act_int  <= w_new_int;
                r_act_frac <= w_new_frac;
                r_pend     <= 1'b0;
            end else if (w_wr_ok) begin
                r_pend <= 1'b1;
            end
            if (resync) begin
                r_os_cnt <= '0;
            end else if (w_wrap) begin
                r_os_cnt <= w_baud_ev ? '0 : r_os_cnt + OS_W'(1);
            end
        end
    end

    assign os_tick   = w_os_tick;
    assign baud_tick = r_baud;
    assign mid_tick  = r_mid;
    assign cfg_err   = r_err;
    assign cfg_pend  = r_pend;

endmodule

// File: tb/tb_uart_baud_gen_frac.sv
// Directed bench for uart_baud_gen_frac at default parameters.
// Expectations follow whether UART_BAUD_FRAC_EN is defined for the build.
module tb_uart_baud_gen_frac;
`ifdef UART_BAUD_FRAC_EN
    localparam bit FR = 1'b1;
`else
    localparam bit FR = 1'b0;
`endif
    localparam int P_A     = FR ? 325 : 326;
    localparam int P_B     = 326;
    localparam int BAUD0   = FR ? 5208 : 5216;
    localparam int MID0    = FR ? 2604 : 2608;
    localparam int RS_OS   = FR ? 325 : 326;
    localparam int RS_MID  = FR ? 2603 : 2608;
    localparam int B26     = FR ? 417 : 416;
    localparam int E_MID   = FR ? 2603 : 2600;
    localparam int EN_DLY  = FR ? 1326 : 1325;
    localparam int BUDGET  = 12000;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        cfg_wr;
    logic [15:0] cfg_div_int;
    logic [3:0]  cfg_div_frac;
    logic        resync;
    logic        os_tick;
    logic        baud_tick;
    logic        mid_tick;
    logic        cfg_err;
    logic        cfg_pend;

    int cyc = 0;
    int n_assert = 0;
    int n_fail = 0;

    uart_baud_gen_frac dut (
        .clk          (clk),
        .rst          (rst),
        .en           (en),
        .cfg_wr       (cfg_wr),
        .cfg_div_int  (cfg_div_int),
        .cfg_div_frac (cfg_div_frac),
        .resync       (resync),
        .os_tick      (os_tick),
        .baud_tick    (baud_tick),
        .mid_tick     (mid_tick),
        .cfg_err      (cfg_err),
        .cfg_pend     (cfg_pend)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_n(input string tag, input int obs, input int exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_b(input string tag, input logic obs, input logic exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    // sel: 0 os_tick, 1 baud_tick, 2 mid_tick; returns cycle of the tick
    task automatic wait_tick(input int sel, input string tag, output int at);
        logic hit;
        hit = 1'b0;
        for (int i = 0; i < BUDGET && !hit; i++) begin
            @(negedge clk);
            if ((sel == 0 && os_tick) || (sel == 1 && baud_tick) ||
                (sel == 2 && mid_tick))
                hit = 1'b1;
        end
        at = cyc;
        check_b({tag, "_seen"}, hit, 1'b1);
    endtask

    initial begin
        int r, t1, t2, t3, t4, b1, b2, b3, b4, b5, b6, m1, k, x;
        logic seen;
        rst = 1'b1;
        en = 1'b1;
        cfg_wr = 1'b0;
        resync = 1'b0;
        cfg_div_int = '0;
        cfg_div_frac = '0;
        repeat (3) @(negedge clk);
        check_b("rst_os", os_tick, 1'b0);
        check_b("rst_baud", baud_tick, 1'b0);
        check_b("rst_mid", mid_tick, 1'b0);
        check_b("rst_err", cfg_err, 1'b0);
        check_b("rst_pend", cfg_pend, 1'b0);

        rst = 1'b0;
        r = cyc;
        wait_tick(0, "os1", t1);
        check_n("first_os", t1 - r, P_A);
        wait_tick(0, "os2", t2);
        check_n("os_per2", t2 - t1, P_A);
        wait_tick(0, "os3", t3);
        check_n("os_per3", t3 - t2, P_B);
        wait_tick(0, "os4", t4);
        check_n("os_per4", t4 - t3, P_A);
        wait_tick(1, "baud1", b1);
        wait_tick(2, "mid1", m1);
        check_n("mid_after_baud", m1 - b1, MID0);
        wait_tick(1, "baud2", b2);
        check_n("baud_period", b2 - b1, BAUD0);
        check_b("baud_in_os", os_tick, 1'b1);

        // rejected write
        @(negedge clk);
        cfg_wr = 1'b1;
        cfg_div_int = 16'd1;
        cfg_div_frac = 4'd3;
        @(negedge clk);
        cfg_wr = 1'b0;
        check_b("err_pulse", cfg_err, 1'b1);
        check_b("err_no_pend", cfg_pend, 1'b0);
        @(negedge clk);
        check_b("err_one_cycle", cfg_err, 1'b0);
        wait_tick(1, "baud3", b3);
        check_n("err_period_kept", b3 - b2, BAUD0);

        // resync at cnt=100, os_cnt=7
        for (int i = 0; i < 7; i++) wait_tick(0, "rs_pre", x);
        repeat (100) @(negedge clk);
        resync = 1'b1;
        @(negedge clk);
        resync = 1'b0;
        k = cyc;
        check_b("rs_no_os", os_tick, 1'b0);
        check_b("rs_no_mid", mid_tick, 1'b0);
        wait_tick(0, "rs_os", x);
        check_n("rs_first_os", x - k, RS_OS);
        wait_tick(2, "rs_mid", x);
        check_n("rs_first_mid", x - k, RS_MID);

        // write 26 + 1/16 mid-bit
        wait_tick(2, "d_mid", x);
        cfg_wr = 1'b1;
        cfg_div_int = 16'd26;
        cfg_div_frac = 4'd1;
        @(negedge clk);
        cfg_wr = 1'b0;
        check_b("d_pend_set", cfg_pend, 1'b1);
        repeat (3) @(negedge clk);
        check_b("d_pend_hold", cfg_pend, 1'b1);
        wait_tick(1, "d_baud4", b4);
        check_b("d_pend_clr", cfg_pend, 1'b0);
        wait_tick(1, "d_baud5", b5);
        check_n("d_bit1", b5 - b4, B26);
        wait_tick(1, "d_baud6", b6);
        check_n("d_bit2", b6 - b5, B26);

        // resync + write together, on a terminal count
        wait_tick(0, "e_os0", x);
        repeat (25) @(negedge clk);
        resync = 1'b1;
        cfg_wr = 1'b1;
        cfg_div_int = 16'd325;
        cfg_div_frac = 4'd8;
        @(negedge clk);
        resync = 1'b0;
        cfg_wr = 1'b0;
        k = cyc;
        check_b("e_coinc_no_os", os_tick, 1'b0);
        check_b("e_no_pend", cfg_pend, 1'b0);
        wait_tick(0, "e_os", x);
        check_n("e_first_os", x - k, 325);
        wait_tick(2, "e_mid", m1);
        check_n("e_first_mid", m1 - k, E_MID);

        // en low for 1000 cycles mid-period
        repeat (50) @(negedge clk);
        en = 1'b0;
        seen = 1'b0;
        repeat (1000) begin
            @(negedge clk);
            if (os_tick || baud_tick || mid_tick) seen = 1'b1;
        end
        en = 1'b1;
        check_b("en_quiet", seen, 1'b0);
        wait_tick(0, "f_os", x);
        check_n("en_resume", x - m1, EN_DLY);

        // reset mid-period with a pending write
        @(negedge clk);
        cfg_wr = 1'b1;
        cfg_div_int = 16'd100;
        cfg_div_frac = 4'd0;
        @(negedge clk);
        cfg_wr = 1'b0;
        check_b("g_pend", cfg_pend, 1'b1);
        repeat (20) @(negedge clk);
        rst = 1'b1;
        #1;
        check_b("g_rst_pend", cfg_pend, 1'b0);
        check_b("g_rst_os", os_tick, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        r = cyc;
        wait_tick(0, "g_os1", t1);
        check_n("g_first_os", t1 - r, P_A);
        wait_tick(0, "g_os2", t2);
        check_n("g_os_per2", t2 - t1, P_A);
        wait_tick(0, "g_os3", t3);
        check_n("g_os_per3", t3 - t2, P_B);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule
